data_memory_mp: RTL

- Parametrised multi-port word memory for the pipeline data path, successor to the fixed 4R/4W data memory.
- Generalises read/write port count, width and depth; adds per-byte write enables and deterministic same-address write priority.
- Adds a clock-sequenced clear sweep with a busy flag, replacing the single-cycle array clear.
- Adds a write-collision flag.

---
 rtl/data_memory_mp.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_memory_mp.sv
// Parametrised multi-port word memory: per-byte write enables, per-byte port priority,
// clock-sequenced clear sweep and write-collision flag. Optional: DMEM_REG_READ_EN.
module data_memory_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int NUM_RD = 4,
   parameter int NUM_WR = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*DATA_W/8-1:0] wr_be,
   input  logic                       clear_req,
   output logic                       init_busy,
   output logic                       wr_collision
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {SWEEP = 1'b0, READY = 1'b1} state_t;

   state_t                   state_r;
   state_t                   state_next_s;
   logic [IDX_W-1:0]         ptr_r;
   logic [IDX_W-1:0]         ptr_next_s;
   logic                     init_busy_r;
   logic                     wr_collision_r;
   logic                     collision_s;
   logic [NUM_RD*DATA_W-1:0] rd_word_s;
   logic [DATA_W-1:0]        mem_r [DEPTH];

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_A);
   endfunction

   function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a);
   endfunction

   // Sweep sequencing: walk every word once, then serve user traffic until a clear request.
   always_comb begin
      state_next_s = state_r;
      ptr_next_s   = ptr_r;
      case (state_r)
         SWEEP: begin
            if (ptr_r == LAST_IDX) begin
               state_next_s = READY;
               ptr_next_s   = '0;
            end else begin
               ptr_next_s   = ptr_r + IDX_W'(1);
            end
         end
         READY: begin
            ptr_next_s = '0;
            if (clear_req) begin
               state_next_s = SWEEP;
            end else begin
               state_next_s = READY;
            end
         end
         default: begin
            state_next_s = SWEEP;
            ptr_next_s   = '0;
         end
      endcase
   end

   // Collision detect: any enabled in-range port pair sharing an address and at least one byte.
   always_comb begin
      collision_s = 1'b0;
      if (state_r == READY) begin
         for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
               collision_s = collision_s
                  | (wr_en[i] & wr_en[j]
                     & in_range(wr_addr[i*ADDR_W +: ADDR_W])
                     & in_range(wr_addr[j*ADDR_W +: ADDR_W])
                     & (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
                     & ((wr_be[i*NB +: NB] & wr_be[j*NB +: NB]) != '0));
            end
         end
      end else begin
         collision_s = 1'b0;
      end
   end

   // Control registers; busy mirrors the next state so it drops on the last sweep write.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r        <= SWEEP;
         ptr_r          <= '0;
         init_busy_r    <= 1'b1;
         wr_collision_r <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         ptr_r          <= ptr_next_s;
         init_busy_r    <= (state_next_s == SWEEP);
         wr_collision_r <= collision_s;
      end
   end

   // Array update; later ports are assigned last so the highest index wins each byte.
   always_ff @(posedge clock) begin
      if (state_r == SWEEP) begin
         mem_r[ptr_r] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            for (int b = 0; b < NB; b++) begin
               if (wr_en[j] && wr_be[j*NB + b] && in_range(wr_addr[j*ADDR_W +: ADDR_W])) begin
                  mem_r[to_idx(wr_addr[j*ADDR_W +: ADDR_W])][b*8 +: 8] <= wr_data[j*DATA_W + b*8 +: 8];
               end
            end
         end
      end
   end

   // Read path: zero while sweeping or when the address lies beyond the array.
   always_comb begin
      rd_word_s = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (!init_busy_r && in_range(rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_word_s[i*DATA_W +: DATA_W] = mem_r[to_idx(rd_addr[i*ADDR_W +: ADDR_W])];
         end else begin
            rd_word_s[i*DATA_W +: DATA_W] = '0;
         end
      end
   end

`ifdef DMEM_REG_READ_EN
   logic [NUM_RD*DATA_W-1:0] rd_data_r;

   // Registered read captures the pre-write array content at each edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_data_r <= '0;
      end else begin
         rd_data_r <= rd_word_s;
      end
   end

   assign rd_data = rd_data_r;
`else
   assign rd_data = rd_word_s;
`endif

   assign init_busy    = init_busy_r;
   assign wr_collision = wr_collision_r;

endmodule
